// File: rtl/audio_pkg.sv
// audio_pkg: shared constants, the sequencer state type and helper functions
// for the audio sample path (ADC reader -> sequencer -> IIR stage -> PWM DAC).
package audio_pkg;

   // Default sample width of the audio path, in bits.
   localparam int AUDIO_N = 10;

   // Sequencer states. The encoding is fixed so it reads cleanly on a debug port.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILT   = 2'd1,
      COMMIT = 2'd2
   } seq_state_t;

   // Midscale of an n-bit offset-binary word, which represents silence.
   function automatic int midscale(input int n);
      return 1 << (n - 1);
   endfunction

   // Clock cycles per sample period. The division truncates toward zero.
   function automatic int div_calc(input int clk_hz, input int fs_hz);
      return clk_hz / fs_hz;
   endfunction

endpackage

// File: rtl/audio_sample_seq_fs_tick_gen.sv
// fs_tick_gen: free-running modulo-DIV counter that emits a one-cycle tick
// on the last count of each period. It is generic, so any block that needs a
// slow periodic strobe (sample rate, pot scanning) can instantiate it.
module fs_tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   // Count 0..DIV-1 and wrap; runs regardless of what the consumer is doing.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tick = (r_cnt == LAST);

endmodule

// File: rtl/audio_sample_seq.sv
// audio_sample_seq: sample-rate sequencer between the ADC reader and the
// first-order IIR stage. It generates the fs strobe, keeps the x[n], x[n-1]
// and y[n-1] history, launches one filter evaluation per sample and commits
// the result to the PWM DAC input.
// Optional build macro AUDIO_SAMPLE_SEQ_MUTE_EN adds a mute input that forces
// the DAC to midscale while the filter history keeps updating.
//
// Filter handshake: filt_start is a one-cycle pulse meaning x_n/x_n1/y_n1 are
// valid and stay stable until the commit. The filter answers with filt_done
// (level or pulse) together with filt_y. filt_done is only honoured in the
// cycles after the filt_start pulse, so a level left high from the previous
// evaluation cannot be mistaken for a new answer. If no answer comes within
// TIMEOUT cycles, the previous y_n1 is committed again and timeout sticks.
module audio_sample_seq
   import audio_pkg::*;
#(
   parameter int N       = AUDIO_N,
   parameter int CLK_HZ  = 50000000,
   parameter int FS_HZ   = 48000,
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         adc_valid,
   input  logic [N-1:0] adc_data,
   input  logic         filt_done,
   input  logic [N-1:0] filt_y,
`ifdef AUDIO_SAMPLE_SEQ_MUTE_EN
   input  logic         mute,
`endif
   output logic         fs_tick,
   output logic [N-1:0] x_n,
   output logic [N-1:0] x_n1,
   output logic [N-1:0] y_n1,
   output logic         filt_start,
   output logic [N-1:0] dac_val,
   output logic         dac_update,
   output logic         overrun,
   output logic         timeout,
   output logic         stale,
   output seq_state_t   dbg_state
);

   localparam int            DIV       = div_calc(CLK_HZ, FS_HZ);
   localparam logic [N-1:0]  MID       = N'(midscale(N));
   localparam int            TW        = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

   seq_state_t    r_state;
   seq_state_t    w_next;
   logic          w_tick;
   logic          w_tick_take;
   logic          w_done_seen;
   logic          w_expired;
   logic          w_commit;
   logic [N-1:0]  w_sample;
   logic [N-1:0]  w_result;
   logic [N-1:0]  w_dac_next;
   logic          r_first;
   logic [TW-1:0] r_wait;
   logic [N-1:0]  r_hold;
   logic          r_fresh;
   logic [N-1:0]  r_x_n;
   logic [N-1:0]  r_x_n1;
   logic [N-1:0]  r_y_n1;
   logic [N-1:0]  r_dac;
   logic          r_stale;
   logic          r_overrun;
   logic          r_timeout;

   fs_tick_gen #(
      .DIV   (DIV)
   ) u_fs_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (w_tick)
   );

   // A tick is only consumed in IDLE; anywhere else it is dropped as an overrun.
   assign w_tick_take = w_tick && (r_state == IDLE);
   // A word arriving in the tick cycle itself is used directly instead of the older hold value.
   assign w_sample    = adc_valid ? adc_data : r_hold;
   assign w_done_seen = (r_state == FILT) && !r_first && filt_done;
   assign w_expired   = (r_state == FILT) && !r_first && !filt_done && (r_wait == LAST_WAIT);
   assign w_commit    = w_done_seen || w_expired;
   assign w_result    = w_done_seen ? filt_y : r_y_n1;

`ifdef AUDIO_SAMPLE_SEQ_MUTE_EN
   assign w_dac_next  = mute ? MID : w_result;
`else
   assign w_dac_next  = w_result;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic: IDLE -> FILT on a tick, FILT -> COMMIT on answer or expiry, COMMIT -> IDLE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_tick)   w_next = FILT;
         FILT:    if (w_commit) w_next = COMMIT;
         COMMIT:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Control outputs decoded from the state and the first-cycle-of-FILT flag.
   always_comb begin
      filt_start = (r_state == FILT) && r_first;
      dac_update = (r_state == COMMIT);
      dbg_state  = r_state;
   end

   // Sample history, ADC hold register and sticky status flags.
   // y_n1/dac_val load on entry to COMMIT so dac_val already shows the new value while dac_update is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_first   <= 1'b0;
         r_wait    <= '0;
         r_hold    <= MID;
         r_fresh   <= 1'b0;
         r_x_n     <= MID;
         r_x_n1    <= MID;
         r_y_n1    <= MID;
         r_dac     <= MID;
         r_stale   <= 1'b0;
         r_overrun <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_first <= w_tick_take;
         r_stale <= w_tick_take && !r_fresh && !adc_valid;

         if (adc_valid) begin
            r_hold  <= adc_data;
            r_fresh <= 1'b1;
         end
         if (w_tick_take) begin
            r_fresh <= 1'b0;
            r_x_n   <= w_sample;
            r_x_n1  <= r_x_n;
         end

         if (w_tick && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
         end

         if ((r_state != FILT) || r_first) begin
            r_wait <= '0;
         end else begin
            r_wait <= r_wait + 1'b1;
         end

         if (w_expired) begin
            r_timeout <= 1'b1;
         end
         if (w_commit) begin
            r_y_n1 <= w_result;
            r_dac  <= w_dac_next;
         end
      end
   end

   assign fs_tick = w_tick;
   assign x_n     = r_x_n;
   assign x_n1    = r_x_n1;
   assign y_n1    = r_y_n1;
   assign dac_val = r_dac;
   assign stale   = r_stale;
   assign overrun = r_overrun;
   assign timeout = r_timeout;

endmodule

// File: tb/tb_audio_sample_seq.sv
// tb_audio_sample_seq: directed test of audio_sample_seq with DIV = 10
// (CLK_HZ = 1000, FS_HZ = 100) and TIMEOUT = 64. Expected DAC commits are
// queued in exp_q and popped at each dac_update.
// Build with +define+AUDIO_SAMPLE_SEQ_MUTE_EN to exercise the mute input.
module tb_audio_sample_seq;
   import audio_pkg::*;

   localparam int N = 10;

   logic         clk;
   logic         reset;
   logic         adc_valid;
   logic [N-1:0] adc_data;
   logic         filt_done;
   logic [N-1:0] filt_y;
   logic [N-1:0] filt_y_drv;
   logic         loop_en;
`ifdef AUDIO_SAMPLE_SEQ_MUTE_EN
   logic         mute;
`endif
   logic         fs_tick;
   logic [N-1:0] x_n;
   logic [N-1:0] x_n1;
   logic [N-1:0] y_n1;
   logic         filt_start;
   logic [N-1:0] dac_val;
   logic         dac_update;
   logic         overrun;
   logic         timeout;
   logic         stale;
   seq_state_t   dbg_state;

   logic [N-1:0] exp_q[$];
   int           n_checks;
   int           n_fail;
   int           cyc;

   // Pass-through filter model: y[n] = x[n] when loop_en, otherwise a fixed value.
   assign filt_y = loop_en ? x_n : filt_y_drv;

   audio_sample_seq #(
      .N          (N),
      .CLK_HZ     (1000),
      .FS_HZ      (100),
      .TIMEOUT    (64)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .adc_valid  (adc_valid),
      .adc_data   (adc_data),
      .filt_done  (filt_done),
      .filt_y     (filt_y),
`ifdef AUDIO_SAMPLE_SEQ_MUTE_EN
      .mute       (mute),
`endif
      .fs_tick    (fs_tick),
      .x_n        (x_n),
      .x_n1       (x_n1),
      .y_n1       (y_n1),
      .filt_start (filt_start),
      .dac_val    (dac_val),
      .dac_update (dac_update),
      .overrun    (overrun),
      .timeout    (timeout),
      .stale      (stale),
      .dbg_state  (dbg_state)
   );

   // Clock and watchdog.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_adc(input logic [N-1:0] v);
      adc_valid = 1'b1;
      adc_data  = v;
      step();
      adc_valid = 1'b0;
   endtask

   task automatic wait_tick(input string tag);
      int k;
      k = 0;
      while (fs_tick !== 1'b1 && k < 40) begin
         step();
         k++;
      end
      check_val(tag, {31'd0, fs_tick}, 32'd1);
   endtask

   task automatic check_commit(input string tag);
      logic [N-1:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      check_val({tag, "_upd"}, {31'd0, dac_update}, 32'd1);
      check_val({tag, "_val"}, {22'd0, dac_val}, {22'd0, e});
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      reset      = 1'b1;
      adc_valid  = 1'b0;
      adc_data   = '0;
      filt_done  = 1'b1;
      filt_y_drv = '0;
      loop_en    = 1'b1;
`ifdef AUDIO_SAMPLE_SEQ_MUTE_EN
      mute       = 1'b0;
`endif
      repeat (3) step();

      // Reset state
      check_val("rst_tick", {31'd0, fs_tick}, 32'd0);
      check_val("rst_x_n", {22'd0, x_n}, 32'd512);
      check_val("rst_x_n1", {22'd0, x_n1}, 32'd512);
      check_val("rst_y_n1", {22'd0, y_n1}, 32'd512);
      check_val("rst_dac", {22'd0, dac_val}, 32'd512);
      check_val("rst_flags", {26'd0, filt_start, dac_update, stale, overrun, timeout, 1'b0}, 32'd0);
      check_val("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
      reset = 1'b0;

      // 1: first tick on the 10th cycle after release, stale, one-cycle filt_start
      cyc = 1;
      while (fs_tick !== 1'b1 && cyc < 30) begin
         step();
         cyc++;
      end
      check_val("t1_first_tick_cycle", cyc, 32'd10);
      check_val("t1_start_at_T", {31'd0, filt_start}, 32'd0);
      exp_q.push_back(10'd512);
      step();
      check_val("t1_start_T1", {31'd0, filt_start}, 32'd1);
      check_val("t1_stale_T1", {31'd0, stale}, 32'd1);
      check_val("t1_x_n", {22'd0, x_n}, 32'd512);
      check_val("t1_x_n1", {22'd0, x_n1}, 32'd512);
      check_val("t1_state_T1", {30'd0, dbg_state}, {30'd0, FILT});
      step();
      check_val("t1_start_T2", {31'd0, filt_start}, 32'd0);
      check_val("t1_stale_T2", {31'd0, stale}, 32'd0);
      check_val("t1_upd_T2", {31'd0, dac_update}, 32'd0);
      step();
      check_commit("t1_T3");
      check_val("t1_y_n1", {22'd0, y_n1}, 32'd512);
      step();
      check_val("t1_upd_T4", {31'd0, dac_update}, 32'd0);
      check_val("t1_state_T4", {30'd0, dbg_state}, {30'd0, IDLE});

      // 2: 300 then 700 on consecutive ticks, pass-through filter
      pulse_adc(10'd300);
      wait_tick("t2a_tick");
      exp_q.push_back(10'd300);
      step();
      check_val("t2a_x_n", {22'd0, x_n}, 32'd300);
      check_val("t2a_x_n1", {22'd0, x_n1}, 32'd512);
      check_val("t2a_stale", {31'd0, stale}, 32'd0);
      step();
      step();
      check_commit("t2a_T3");
      step();
      pulse_adc(10'd700);
      wait_tick("t2b_tick");
      exp_q.push_back(10'd700);
      step();
      check_val("t2b_x_n", {22'd0, x_n}, 32'd700);
      check_val("t2b_x_n1", {22'd0, x_n1}, 32'd300);
      step();
      step();
      check_commit("t2b_T3");
      check_val("t2b_y_n1", {22'd0, y_n1}, 32'd700);
      step();

      // 3: ADC word in the tick cycle itself is bypassed into x_n
      wait_tick("t3_tick");
      adc_valid = 1'b1;
      adc_data  = 10'd123;
      exp_q.push_back(10'd123);
      step();
      adc_valid = 1'b0;
      check_val("t3_x_n", {22'd0, x_n}, 32'd123);
      check_val("t3_x_n1", {22'd0, x_n1}, 32'd700);
      check_val("t3_stale", {31'd0, stale}, 32'd0);
      step();
      step();
      check_commit("t3_T3");
      step();

      // 3b: no new word, hold value reused and stale pulses; filter answers 456
      loop_en    = 1'b0;
      filt_y_drv = 10'd456;
      wait_tick("t3b_tick");
      exp_q.push_back(10'd456);
      step();
      check_val("t3b_x_n", {22'd0, x_n}, 32'd123);
      check_val("t3b_x_n1", {22'd0, x_n1}, 32'd123);
      check_val("t3b_stale", {31'd0, stale}, 32'd1);
      step();
      step();
      check_commit("t3b_T3");
      check_val("t3b_y_n1", {22'd0, y_n1}, 32'd456);
      step();

      // 4: filt_done only during filt_start, then low -> timeout, prior y_n1 reused, overrun
      filt_done = 1'b0;
      wait_tick("t4_tick");
      exp_q.push_back(10'd456);
      step();
      filt_done = 1'b1;
      check_val("t4_start", {31'd0, filt_start}, 32'd1);
      check_val("t4_ovr_T1", {31'd0, overrun}, 32'd0);
      step();
      filt_done = 1'b0;
      check_val("t4_done_ignored", {31'd0, dac_update}, 32'd0);
      for (int k = 3; k <= 66; k++) begin
         step();
         if (k == 10) check_val("t4_ovr_T10", {31'd0, overrun}, 32'd0);
         if (k == 11) begin
            check_val("t4_ovr_T11", {31'd0, overrun}, 32'd1);
            check_val("t4_hist_kept", {22'd0, x_n}, 32'd123);
         end
         if (k == 65) begin
            check_val("t4_tmo_T65", {31'd0, timeout}, 32'd0);
            check_val("t4_upd_T65", {31'd0, dac_update}, 32'd0);
         end
      end
      check_val("t4_tmo_T66", {31'd0, timeout}, 32'd1);
      check_commit("t4_T66");
      check_val("t4_y_n1", {22'd0, y_n1}, 32'd456);
      step();
      check_val("t4_tmo_sticky", {31'd0, timeout}, 32'd1);
      check_val("t4_state", {30'd0, dbg_state}, {30'd0, IDLE});

      // 5: reset during FILT, then a late filt_done is ignored
      wait_tick("t5_tick");
      step();
      check_val("t5_state_T1", {30'd0, dbg_state}, {30'd0, FILT});
      step();
      reset = 1'b1;
      step();
      reset      = 1'b0;
      filt_done  = 1'b1;
      filt_y_drv = 10'd999;
      check_val("t5_state", {30'd0, dbg_state}, {30'd0, IDLE});
      check_val("t5_x_n", {22'd0, x_n}, 32'd512);
      check_val("t5_x_n1", {22'd0, x_n1}, 32'd512);
      check_val("t5_y_n1", {22'd0, y_n1}, 32'd512);
      check_val("t5_dac", {22'd0, dac_val}, 32'd512);
      check_val("t5_flags", {27'd0, filt_start, dac_update, stale, overrun, timeout}, 32'd0);
      step();
      filt_done = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check_val("t5_no_upd", {31'd0, dac_update}, 32'd0);
         check_val("t5_idle", {30'd0, dbg_state}, {30'd0, IDLE});
         step();
      end
      check_val("t5_dac_after", {22'd0, dac_val}, 32'd512);

      // 6: filter answers 900; with mute the DAC holds midscale but y_n1 tracks
      filt_done  = 1'b1;
      filt_y_drv = 10'd900;
`ifdef AUDIO_SAMPLE_SEQ_MUTE_EN
      mute = 1'b1;
      exp_q.push_back(10'd512);
`else
      exp_q.push_back(10'd900);
`endif
      wait_tick("t6_tick");
      step();
      step();
      step();
      check_commit("t6_T3");
      check_val("t6_y_n1", {22'd0, y_n1}, 32'd900);
      step();
`ifdef AUDIO_SAMPLE_SEQ_MUTE_EN
      mute = 1'b0;
      exp_q.push_back(10'd900);
      wait_tick("t6b_tick");
      step();
      step();
      step();
      check_commit("t6b_T3");
      step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
